add_seq_ctrl: RTL and testbench
===============================

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 SHALL have parameter N_NIB, default 4: number of 4-bit nibbles per operand; operand width W = 4*N_NIB; legal range 2..8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin one W-bit addition.
REQ-005 SHALL have port op_a  input  W  operand A, sampled only when start is accepted.
REQ-006 SHALL have port op_b  input  W  operand B, sampled only when start is accepted.
REQ-007 SHALL have port c_in  input  1  carry-in of the whole addition, sampled with the operands.
REQ-008 SHALL have port add_a  output  4  nibble of A driven to the 4-bit adder stage.
REQ-009 SHALL have port add_b  output  4  nibble of B driven to the 4-bit adder stage.
REQ-010 SHALL have port add_cin  output  1  carry driven to the 4-bit adder stage.
REQ-011 SHALL have port add_sum  input  4  sum returned by the 4-bit adder stage (combinational, same cycle).
REQ-012 SHALL have port add_cout  input  1  carry-out returned by the 4-bit adder stage.
REQ-013 SHALL have port busy  output  1  high while an addition is in progress or completing.
REQ-014 SHALL have port done  output  1  one-cycle pulse; result and c_out valid.
REQ-015 SHALL have port result  output  W  full W-bit sum.
REQ-016 SHALL have port c_out  output  1  final carry-out.

Function
REQ-017 SHALL implement a registered FSM with states IDLE, RUN, DONE.
REQ-018 IDLE: start=1 at a rising edge SHALL latch op_a, op_b into internal registers, load the carry register with c_in, clear nibble index idx to 0, and go to RUN.
REQ-019 RUN: add_a/add_b SHALL be nibble idx (bits 4*idx+3..4*idx) of the latched operands and add_cin SHALL be the carry register; in IDLE and DONE, add_a, add_b, add_cin SHALL be 0.
REQ-020 RUN: every rising edge SHALL write add_sum into nibble idx of an internal shadow sum, load add_cout into the carry register, and increment idx.
REQ-021 RUN: the edge that captures nibble N_NIB-1 SHALL move the FSM to DONE; idx SHALL never exceed N_NIB-1.
REQ-022 On entry to DONE, result SHALL take the completed shadow sum and c_out SHALL take the final add_cout, both in the same edge.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-024 Latency: for start accepted at edge E0, done SHALL be high in the cycle after edge E0+N_NIB (N_NIB+1 edges from start to done deasserting edge).
REQ-025 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-026 start while busy=1 SHALL be ignored, with no effect on operands, idx, carry or outputs.
REQ-027 start asserted in the cycle after DONE (FSM in IDLE) SHALL be accepted; back-to-back throughput is one addition per N_NIB+2 cycles.
REQ-028 result and c_out SHALL hold their value from the last DONE until the next DONE; partial sums SHALL never appear on result.
REQ-029 Arithmetic: {c_out, result} SHALL equal op_a + op_b + c_in modulo 2^(W+1), given a correct 4-bit adder stage.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, idx=0, carry register 0, shadow sum 0, result=0, c_out=0, busy=0, done=0, add_a=0, add_b=0, add_cin=0.
REQ-031 Reset asserted during RUN or DONE SHALL abort the addition with no done pulse; first start after rst_n rises SHALL be accepted normally.

Verification
REQ-032 start, op_a=0x0003, op_b=0x0007, c_in=0 -> done after 4 edges, result=0x000A, c_out=0.
REQ-033 op_a=0xFFFF, op_b=0x0001, c_in=0 -> add_cin=1 on nibbles 1..3, result=0x0000, c_out=1.
REQ-034 op_a=0x000B, op_b=0x0002, c_in=1 -> result=0x000E, c_out=0; add_a sequence 0xB,0,0,0.
REQ-035 start re-pulsed with op_a=0x1111 during RUN -> ignored; first operation's result unchanged, exactly one done.
REQ-036 rst_n low at second RUN cycle -> all outputs 0 immediately, no done; new start after release gives correct result.
REQ-037 start held high continuously -> additions accepted every 6 cycles, done pulses one cycle each, result holds between pulses.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// Nibble-serial adder sequencer: steps a W-bit addition through an external
// 4-bit adder stage, one nibble per cycle, and presents the full sum on done.
module add_seq_ctrl #(
    parameter int N_NIB = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*N_NIB-1:0]   op_a,
    input  logic [4*N_NIB-1:0]   op_b,
    input  logic                 c_in,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout,
    output logic                 busy,
    output logic                 done,
    output logic [4*N_NIB-1:0]   result,
    output logic                 c_out
);
    localparam int IW = (N_NIB > 1) ? $clog2(N_NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [N_NIB-1:0][3:0]   a_q, b_q, sum_q, sum_nxt;
    logic                    carry_q;
    logic [IW-1:0]           idx_q;
    logic                    last;

    assign last = (idx_q == IW'(N_NIB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        add_a     = 4'd0;
        add_b     = 4'd0;
        add_cin   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        sum_nxt   = sum_q;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy           = 1'b1;
                add_a          = a_q[idx_q];
                add_b          = b_q[idx_q];
                add_cin        = carry_q;
                sum_nxt[idx_q] = add_sum;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // result only updates on the final nibble, so partial sums stay hidden in sum_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            result  <= '0;
            c_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q     <= op_a;
                    b_q     <= op_b;
                    carry_q <= c_in;
                    idx_q   <= '0;
                end
                RUN: begin
                    sum_q   <= sum_nxt;
                    carry_q <= add_cout;
                    if (last) begin
                        result <= sum_nxt;
                        c_out  <= add_cout;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl with a behavioural 4-bit adder stage.
module tb_add_seq_ctrl;
    localparam int N_NIB = 4;
    localparam int W     = 4 * N_NIB;

    logic          clk = 1'b0;
    logic          rst_n, start, c_in;
    logic [W-1:0]  op_a, op_b, result;
    logic [3:0]    add_a, add_b, add_sum;
    logic          add_cin, add_cout, busy, done, c_out;

    int total = 0;
    int bad   = 0;

    logic [3:0] seq_a   [0:7];
    logic       seq_cin [0:7];

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = add_a + add_b + add_cin;

    add_seq_ctrl #(.N_NIB(N_NIB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .c_in(c_in), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .busy(busy), .done(done),
        .result(result), .c_out(c_out)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_res;
        logic         exp_cout;
    } vec_t;

    vec_t vecs [0:8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accepts one operation and waits for done; records per-RUN-cycle adder inputs.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output int lat);
        int k;
        @(negedge clk);
        op_a = a; op_b = b; c_in = cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 8) begin
            seq_a[k]   = add_a;
            seq_cin[k] = add_cin;
            k++;
            @(negedge clk);
        end
        lat = k;
        if (!done) begin
            total++; bad++;
            $display("FAIL run_op timeout: got no done expected done");
        end
    endtask

    initial begin
        int lat, dcnt, ndone, last_c;
        int pulse_c [0:2];

        vecs[0] = '{16'h0003, 16'h0007, 1'b0, 16'h000A, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h000B, 16'h0002, 1'b1, 16'h000E, 1'b0};
        vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; c_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(N_NIB));
            chk($sformatf("v%0d_result", i), 64'(result), 64'(vecs[i].exp_res));
            chk($sformatf("v%0d_cout", i), 64'(c_out), 64'(vecs[i].exp_cout));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
            if (i == 1) begin
                chk("ffff_cin0", 64'(seq_cin[0]), 64'd0);
                chk("ffff_cin1", 64'(seq_cin[1]), 64'd1);
                chk("ffff_cin2", 64'(seq_cin[2]), 64'd1);
                chk("ffff_cin3", 64'(seq_cin[3]), 64'd1);
            end
            if (i == 2) begin
                chk("b_adda0", 64'(seq_a[0]), 64'hB);
                chk("b_adda1", 64'(seq_a[1]), 64'h0);
                chk("b_adda2", 64'(seq_a[2]), 64'h0);
                chk("b_adda3", 64'(seq_a[3]), 64'h0);
                chk("b_cin0", 64'(seq_cin[0]), 64'd1);
            end
            @(negedge clk);
            chk($sformatf("v%0d_idle_done", i), 64'(done), 64'd0);
            chk($sformatf("v%0d_idle_busy", i), 64'(busy), 64'd0);
            chk($sformatf("v%0d_idle_add", i), 64'({add_a, add_b, add_cin}), 64'd0);
            chk($sformatf("v%0d_hold", i), 64'({c_out, result}), 64'({vecs[i].exp_cout, vecs[i].exp_res}));
        end

        // start re-pulsed with different operands mid-run must be ignored
        @(negedge clk);
        op_a = 16'h0003; op_b = 16'h0007; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h1111; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) begin
                dcnt++;
                chk("ign_result", 64'(result), 64'h000A);
                chk("ign_cout", 64'(c_out), 64'd0);
            end
            @(negedge clk);
        end
        chk("ign_done_count", 64'(dcnt), 64'd1);

        // reset in the second RUN cycle aborts with no done
        @(negedge clk);
        op_a = 16'h0FFF; op_b = 16'h0001; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_out", 64'({c_out, result}), 64'd0);
        chk("arst_add", 64'({add_a, add_b, add_cin}), 64'd0);
        dcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (c == 2) rst_n = 1'b1;
        end
        chk("arst_no_done", 64'(dcnt), 64'd0);
        run_op(16'h2468, 16'h1357, 1'b0, lat);
        chk("arst_post_result", 64'(result), 64'h37BF);
        chk("arst_post_lat", 64'(lat), 64'(N_NIB));

        // start held high: one accept per N_NIB+2 cycles
        @(negedge clk);
        @(negedge clk);
        op_a = 16'h1234; op_b = 16'h0001; c_in = 1'b0; start = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40 && ndone < 3; c++) begin
            @(negedge clk);
            if (done) begin
                pulse_c[ndone] = c;
                ndone++;
            end
            if (ndone > 0) chk("cont_result", 64'(result), 64'h1235);
        end
        start = 1'b0;
        chk("cont_pulses", 64'(ndone), 64'd3);
        if (ndone == 3) begin
            chk("cont_gap0", 64'(pulse_c[1] - pulse_c[0]), 64'(N_NIB + 2));
            chk("cont_gap1", 64'(pulse_c[2] - pulse_c[1]), 64'(N_NIB + 2));
        end
        last_c = 0;
        repeat (8) @(negedge clk);
        chk("cont_end_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
